// File: rtl/req_grant_dispatcher_if.sv
// Grant-path bundle for req_grant_dispatcher: request pulses in, indexed valid/ready grant out.
// master = dispatcher side, slave = requesters/consumer side.
interface req_grant_dispatcher_if #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = $clog2(WIDTH)
);
  logic [WIDTH-1:0]      req;
  logic [ADDR_WIDTH-1:0] gnt_idx;
  logic                  gnt_valid;
  logic                  gnt_ready;
  logic                  done;
  logic [WIDTH-1:0]      pending;
  logic                  busy;
  logic                  timeout;

  modport master (
    input  req, gnt_ready, done,
    output gnt_idx, gnt_valid, pending, busy, timeout
  );

  modport slave (
    output req, gnt_ready, done,
    input  gnt_idx, gnt_valid, pending, busy, timeout
  );
endinterface

// File: rtl/req_grant_dispatcher.sv
// Sticky request capture + highest-index pick, served one at a time over a valid/ready grant.
// Optional BUSY watchdog: define REQ_GRANT_DISPATCHER_BUSY_TIMEOUT_EN.
module req_grant_dispatcher #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = $clog2(WIDTH),
  parameter int TIMEOUT    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  req_grant_dispatcher_if.master bus
);

  if (WIDTH < 2)   begin : g_bad_width   $error("WIDTH must be >= 2");   end
  if (TIMEOUT < 1) begin : g_bad_timeout $error("TIMEOUT must be >= 1"); end

  typedef enum logic [1:0] {IDLE, OFFER, BUSY} state_e;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      pending_q, pending_d;
  logic [ADDR_WIDTH-1:0] gnt_idx_q, gnt_idx_d;
  logic                  gnt_valid_q, gnt_valid_d;
  logic                  busy_q, busy_d;
  logic [WIDTH-1:0]      clr_mask;
  logic [WIDTH-1:0]      cand;
  logic [ADDR_WIDTH-1:0] sel;

`ifdef REQ_GRANT_DISPATCHER_BUSY_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  // Same-edge pulses count, so a request can be granted with 1-cycle latency.
  always_comb begin
    cand = pending_q | bus.req;
    sel  = '0;
    for (int i = 0; i < WIDTH; i++)
      if (cand[i]) sel = ADDR_WIDTH'(i);
  end

  always_comb begin
    state_d     = state_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    busy_d      = busy_q;
    clr_mask    = '0;
`ifdef REQ_GRANT_DISPATCHER_BUSY_TIMEOUT_EN
    cnt_d       = cnt_q;
    timeout_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|cand) begin
          gnt_idx_d   = sel;
          gnt_valid_d = 1'b1;
          busy_d      = 1'b1;
          state_d     = OFFER;
        end
      end
      OFFER: begin
        if (bus.gnt_ready) begin
          clr_mask[gnt_idx_q] = 1'b1;
          gnt_valid_d         = 1'b0;
          state_d             = BUSY;
`ifdef REQ_GRANT_DISPATCHER_BUSY_TIMEOUT_EN
          cnt_d               = '0;
`endif
        end
      end
      BUSY: begin
        if (bus.done) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
`ifdef REQ_GRANT_DISPATCHER_BUSY_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          busy_d    = 1'b0;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d     = IDLE;
        gnt_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
    // OR-ing req after the clear makes a colliding pulse win over the clear.
    pending_d = (pending_q & ~clr_mask) | bus.req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      busy_q      <= busy_d;
    end
  end

`ifdef REQ_GRANT_DISPATCHER_BUSY_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.pending   = pending_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_req_grant_dispatcher.sv
// Directed bench for req_grant_dispatcher: inputs change 1ns after a rising edge, outputs checked there too.
module tb_req_grant_dispatcher;
  localparam int WIDTH = 8;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  req_grant_dispatcher_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) bus ();

  req_grant_dispatcher #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] r, input logic rdy, input logic dn);
    bus.req       = r;
    bus.gnt_ready = rdy;
    bus.done      = dn;
  endtask

  task automatic test_reset();
    drive(8'hFF, 1'b0, 1'b0);
    rst_n = 1'b0;
    cyc();
    cyc();
    checks++; if (bus.pending !== 8'h00) begin errors++; $display("FAIL rst_pending got=%h want=00", bus.pending); end
    checks++; if ({bus.gnt_valid, bus.busy, bus.timeout} !== 3'b000) begin errors++; $display("FAIL rst_flags got=%b want=000", {bus.gnt_valid, bus.busy, bus.timeout}); end
    checks++; if (bus.gnt_idx !== 3'd0) begin errors++; $display("FAIL rst_idx got=%0d want=0", bus.gnt_idx); end
    drive(8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc();
    cyc();
    checks++; if (bus.gnt_valid !== 1'b0) begin errors++; $display("FAIL post_rst_valid got=%b want=0", bus.gnt_valid); end
  endtask

  task automatic test_single();
    drive(8'h04, 1'b0, 1'b0);
    cyc();
    checks++; if (bus.gnt_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b want=1", bus.gnt_valid); end
    checks++; if (bus.gnt_idx !== 3'd2) begin errors++; $display("FAIL single_idx got=%0d want=2", bus.gnt_idx); end
    checks++; if (bus.pending !== 8'h04) begin errors++; $display("FAIL single_pending got=%h want=04", bus.pending); end
    drive(8'h00, 1'b1, 1'b0);
    cyc();
    checks++; if ({bus.gnt_valid, bus.busy} !== 2'b01) begin errors++; $display("FAIL single_hs got=%b want=01", {bus.gnt_valid, bus.busy}); end
    checks++; if (bus.pending !== 8'h00) begin errors++; $display("FAIL single_clr got=%h want=00", bus.pending); end
    drive(8'h00, 1'b0, 1'b1);
    cyc();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_done got=%b want=0", bus.busy); end
    drive(8'h00, 1'b1, 1'b0);
    cyc();
    checks++; if ({bus.gnt_valid, bus.busy} !== 2'b00) begin errors++; $display("FAIL idle_ready got=%b want=00", {bus.gnt_valid, bus.busy}); end
    drive(8'h00, 1'b0, 1'b0);
  endtask

  // Handshake then done; leaves the DUT in IDLE.
  task automatic serve();
    drive(8'h00, 1'b1, 1'b0);
    cyc();
    drive(8'h00, 1'b0, 1'b1);
    cyc();
    drive(8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_priority();
    drive(8'h12, 1'b0, 1'b0);
    cyc();
    checks++; if (bus.gnt_idx !== 3'd4) begin errors++; $display("FAIL prio_first got=%0d want=4", bus.gnt_idx); end
    drive(8'h80, 1'b0, 1'b0);
    cyc();
    checks++; if (bus.gnt_idx !== 3'd4 || bus.gnt_valid !== 1'b1) begin errors++; $display("FAIL no_preempt got=%0d/%b want=4/1", bus.gnt_idx, bus.gnt_valid); end
    checks++; if (bus.pending !== 8'h92) begin errors++; $display("FAIL prio_pending got=%h want=92", bus.pending); end
    serve();
    cyc();
    checks++; if (bus.gnt_idx !== 3'd7 || bus.gnt_valid !== 1'b1) begin errors++; $display("FAIL prio_second got=%0d/%b want=7/1", bus.gnt_idx, bus.gnt_valid); end
    serve();
    cyc();
    checks++; if (bus.gnt_idx !== 3'd1 || bus.gnt_valid !== 1'b1) begin errors++; $display("FAIL prio_third got=%0d/%b want=1/1", bus.gnt_idx, bus.gnt_valid); end
    serve();
    checks++; if (bus.pending !== 8'h00) begin errors++; $display("FAIL prio_drain got=%h want=00", bus.pending); end
  endtask

  task automatic test_set_wins();
    drive(8'h08, 1'b0, 1'b0);
    cyc();
    checks++; if (bus.gnt_idx !== 3'd3) begin errors++; $display("FAIL sw_idx got=%0d want=3", bus.gnt_idx); end
    drive(8'h08, 1'b1, 1'b0);
    cyc();
    checks++; if (bus.pending !== 8'h08 || bus.gnt_valid !== 1'b0) begin errors++; $display("FAIL sw_keep got=%h/%b want=08/0", bus.pending, bus.gnt_valid); end
    drive(8'h00, 1'b0, 1'b1);
    cyc();
    drive(8'h00, 1'b0, 1'b0);
    cyc();
    checks++; if (bus.gnt_idx !== 3'd3 || bus.gnt_valid !== 1'b1) begin errors++; $display("FAIL sw_regrant got=%0d/%b want=3/1", bus.gnt_idx, bus.gnt_valid); end
    serve();
  endtask

  task automatic test_reset_mid();
    drive(8'h01, 1'b0, 1'b0);
    cyc();
    drive(8'h02, 1'b1, 1'b0);
    cyc();
    drive(8'h00, 1'b0, 1'b0);
    checks++; if (bus.busy !== 1'b1 || bus.pending !== 8'h02) begin errors++; $display("FAIL mid_pre got=%b/%h want=1/02", bus.busy, bus.pending); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({bus.gnt_valid, bus.busy, bus.timeout} !== 3'b000 || bus.pending !== 8'h00 || bus.gnt_idx !== 3'd0)
      begin errors++; $display("FAIL mid_async got=%b/%h/%0d want=000/00/0", {bus.gnt_valid, bus.busy, bus.timeout}, bus.pending, bus.gnt_idx); end
    cyc();
    rst_n = 1'b1;
    cyc();
    cyc();
    checks++; if (bus.gnt_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL mid_quiet got=%b/%b want=0/0", bus.gnt_valid, bus.busy); end
    drive(8'h20, 1'b0, 1'b0);
    cyc();
    checks++; if (bus.gnt_idx !== 3'd5 || bus.gnt_valid !== 1'b1) begin errors++; $display("FAIL mid_new got=%0d/%b want=5/1", bus.gnt_idx, bus.gnt_valid); end
    serve();
  endtask

  task automatic test_timeout();
    drive(8'h40, 1'b0, 1'b0);
    cyc();
    drive(8'h00, 1'b1, 1'b0);
    cyc();
    drive(8'h00, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      checks++; if (bus.busy !== 1'b1 || bus.timeout !== 1'b0) begin errors++; $display("FAIL to_wait%0d got=%b/%b want=1/0", i, bus.busy, bus.timeout); end
    end
    cyc();
`ifdef REQ_GRANT_DISPATCHER_BUSY_TIMEOUT_EN
    checks++; if (bus.timeout !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL to_fire got=%b/%b want=1/0", bus.timeout, bus.busy); end
    cyc();
    checks++; if (bus.timeout !== 1'b0 || bus.pending !== 8'h00 || bus.gnt_valid !== 1'b0) begin errors++; $display("FAIL to_after got=%b/%h/%b want=0/00/0", bus.timeout, bus.pending, bus.gnt_valid); end
`else
    checks++; if (bus.timeout !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL to_none got=%b/%b want=0/1", bus.timeout, bus.busy); end
    cyc();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL to_hold got=%b want=1", bus.busy); end
    drive(8'h00, 1'b0, 1'b1);
    cyc();
    drive(8'h00, 1'b0, 1'b0);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL to_done got=%b want=0", bus.busy); end
`endif
  endtask

  initial begin
    drive(8'h00, 1'b0, 1'b0);
    test_reset();
    test_single();
    test_priority();
    test_set_wins();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
